mem_port_arbiter: RTL

- Shares one synchronous memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- The memory port has the same interface as the data memory: WE, 16-bit ADDR, 32-bit bus, DATA_SIZE, SIGNED.
- Sits between the core front end/LSU and memory. Sequences each access as a 3-state transaction.
- Load/store has priority, with a starvation guard for fetch. Checks alignment before any write is issued.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Arbitrates one synchronous memory port between instruction fetch and load/store.
// Each access runs grant (IDLE) -> ACCESS -> RESP; load/store wins unless fetch is starved.
module mem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_gnt,
   output logic              o_if_rvalid,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_err,
   input  logic              i_ls_req,
   input  logic              i_ls_we,
   input  logic [ADDR_W-1:0] i_ls_addr,
   input  logic [DATA_W-1:0] i_ls_wdata,
   input  logic [1:0]        i_ls_size,
   input  logic              i_ls_signed,
   output logic              o_ls_gnt,
   output logic              o_ls_rvalid,
   output logic [DATA_W-1:0] o_ls_rdata,
   output logic              o_ls_err,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [1:0]        o_mem_size,
   output logic              o_mem_signed,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCESS_IF,
      S_ACCESS_LS,
      S_RESP_IF,
      S_RESP_LS
   } state_t;

   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   state_t              r_state;
   state_t              w_next_state;
   logic [CNT_W-1:0]    r_starve_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [1:0]          r_size;
   logic                r_we;
   logic                r_signed;
   logic                r_err;

   logic w_if_gnt;
   logic w_ls_gnt;
   logic w_if_priority;
   logic w_ls_misaligned;
   logic w_if_misaligned;
   logic w_if_rvalid;
   logic w_ls_rvalid;

   assign w_ls_misaligned = (i_ls_size == 2'b11)
                          | ((i_ls_size == 2'b01) & i_ls_addr[0])
                          | ((i_ls_size == 2'b10) & (i_ls_addr[1:0] != 2'b00));
   assign w_if_misaligned = (i_if_addr[1:0] != 2'b00);
   assign w_if_priority   = (r_starve_cnt == CNT_MAX);

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      w_next_state = r_state;
      w_if_gnt     = 1'b0;
      w_ls_gnt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Grants are held off while reset is asserted.
            if (rst_n) begin
               if (i_ls_req && (!i_if_req || !w_if_priority)) begin
                  w_ls_gnt     = 1'b1;
                  w_next_state = S_ACCESS_LS;
               end else if (i_if_req) begin
                  w_if_gnt     = 1'b1;
                  w_next_state = S_ACCESS_IF;
               end
            end
         end
         S_ACCESS_IF: w_next_state = S_RESP_IF;
         S_ACCESS_LS: w_next_state = S_RESP_LS;
         S_RESP_IF:   w_next_state = S_IDLE;
         S_RESP_LS:   w_next_state = S_IDLE;
         default:     w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_size   <= 2'b00;
         r_we     <= 1'b0;
         r_signed <= 1'b0;
         r_err    <= 1'b0;
      end else if (w_ls_gnt) begin
         r_addr   <= i_ls_addr;
         r_wdata  <= i_ls_wdata;
         r_size   <= i_ls_size;
         r_we     <= i_ls_we;
         r_signed <= i_ls_signed;
         r_err    <= w_ls_misaligned;
      end else if (w_if_gnt) begin
         r_addr   <= i_if_addr;
         r_wdata  <= '0;
         r_size   <= 2'b10;
         r_we     <= 1'b0;
         r_signed <= 1'b0;
         r_err    <= w_if_misaligned;
      end
   end

   // Counts LS wins that kept a waiting fetch out; saturates so fetch wins the next contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (w_if_gnt) begin
         r_starve_cnt <= '0;
      end else if (w_ls_gnt && i_if_req && (r_starve_cnt != CNT_MAX)) begin
         r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
   end

   assign w_if_rvalid = (r_state == S_RESP_IF);
   assign w_ls_rvalid = (r_state == S_RESP_LS);

   assign o_if_gnt     = w_if_gnt;
   assign o_ls_gnt     = w_ls_gnt;
   assign o_if_rvalid  = w_if_rvalid;
   assign o_ls_rvalid  = w_ls_rvalid;
   assign o_if_err     = w_if_rvalid & r_err;
   assign o_ls_err     = w_ls_rvalid & r_err;
   assign o_if_rdata   = (w_if_rvalid && !r_err) ? i_mem_rdata : '0;
   assign o_ls_rdata   = (w_ls_rvalid && !r_err && !r_we) ? i_mem_rdata : '0;

   // Write enable is decoded from state so an asynchronous reset removes it immediately.
   assign o_mem_we     = (r_state == S_ACCESS_LS) & r_we & ~r_err;
   assign o_mem_addr   = r_addr;
   assign o_mem_wdata  = r_wdata;
   assign o_mem_size   = r_size;
   assign o_mem_signed = r_signed;

endmodule
